// File: rtl/neumaier_pair_sched.sv
// neumaier_pair_sched: pairs (sum, comp) partials for the Neumaier merge and tracks their framing tags
module neumaier_pair_sched #(
  parameter int EXP_WIDTH_I = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int MERGE_LATENCY = 5,
  parameter int GRP_CNT_W = 8,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [BIT_WIDTH_I-1:0] sum_i,
  input  logic [BIT_WIDTH_I-1:0] comp_i,
  input  logic                   last_i,
  input  logic                   flush_i,
  output logic [BIT_WIDTH_I-1:0] sum_a_o,
  output logic [BIT_WIDTH_I-1:0] comp_a_o,
  output logic [BIT_WIDTH_I-1:0] sum_b_o,
  output logic [BIT_WIDTH_I-1:0] comp_b_o,
  output logic                   pair_valid_o,
  output logic                   pair_last_o,
  output logic                   merged_valid_o,
  output logic                   merged_last_o,
  output logic [GRP_CNT_W-1:0]   grp_cnt_o
);
  typedef enum logic {EMPTY, HOLD} state_e;
  state_e state_q, state_d;
  logic accept;
  logic ready_q;
  logic pair_valid_q, pair_valid_d;
  logic pair_last_q, pair_last_d;
  logic [BIT_WIDTH_I-1:0] hold_sum_q, hold_sum_d, hold_comp_q, hold_comp_d;
  logic [BIT_WIDTH_I-1:0] sum_a_q, sum_a_d, comp_a_q, comp_a_d;
  logic [BIT_WIDTH_I-1:0] sum_b_q, sum_b_d, comp_b_q, comp_b_d;
  logic [1:0] tag_q [MERGE_LATENCY];
  logic [GRP_CNT_W-1:0] grp_cnt_q;

  assign accept = valid_i && ready_q;

  // Pairing FSM: hold an odd element, close pairs on accept, flush or single-element last
  always_comb begin
    state_d = state_q;
    hold_sum_d = hold_sum_q;
    hold_comp_d = hold_comp_q;
    sum_a_d = sum_a_q;
    comp_a_d = comp_a_q;
    sum_b_d = sum_b_q;
    comp_b_d = comp_b_q;
    pair_valid_d = 1'b0;
    pair_last_d = 1'b0;
    if (state_q == EMPTY) begin
      if (accept && last_i) begin
        pair_valid_d = 1'b1;
        pair_last_d = 1'b1;
        sum_a_d = sum_i;
        comp_a_d = comp_i;
        sum_b_d = '0;
        comp_b_d = '0;
      end else if (accept) begin
        hold_sum_d = sum_i;
        hold_comp_d = comp_i;
        state_d = HOLD;
      end
    end else if (accept || flush_i) begin
      pair_valid_d = 1'b1;
      pair_last_d = accept ? last_i : 1'b1;
      sum_a_d = hold_sum_q;
      comp_a_d = hold_comp_q;
      sum_b_d = accept ? sum_i : '0;
      comp_b_d = accept ? comp_i : '0;
      state_d = EMPTY;
    end
  end

  // State, hold and registered pair outputs; ready rises on the first edge after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      hold_sum_q <= '0;
      hold_comp_q <= '0;
      sum_a_q <= '0;
      comp_a_q <= '0;
      sum_b_q <= '0;
      comp_b_q <= '0;
      pair_valid_q <= 1'b0;
      pair_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      hold_sum_q <= hold_sum_d;
      hold_comp_q <= hold_comp_d;
      sum_a_q <= sum_a_d;
      comp_a_q <= comp_a_d;
      sum_b_q <= sum_b_d;
      comp_b_q <= comp_b_d;
      pair_valid_q <= pair_valid_d;
      pair_last_q <= pair_last_d;
    end
  end

  // Tag pipeline shadowing the merge latency: {valid, last} per pair
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MERGE_LATENCY; i++) tag_q[i] <= 2'b00;
    end else begin
      tag_q[0] <= {pair_valid_q, pair_last_q};
      for (int i = 1; i < MERGE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Completed-group counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) grp_cnt_q <= '0;
    else if (merged_valid_o && merged_last_o) grp_cnt_q <= grp_cnt_q + 1'b1;
  end

  assign ready_o = ready_q;
  assign sum_a_o = sum_a_q;
  assign comp_a_o = comp_a_q;
  assign sum_b_o = sum_b_q;
  assign comp_b_o = comp_b_q;
  assign pair_valid_o = pair_valid_q;
  assign pair_last_o = pair_last_q;
  assign merged_valid_o = tag_q[MERGE_LATENCY-1][1];
  assign merged_last_o = tag_q[MERGE_LATENCY-1][1] & tag_q[MERGE_LATENCY-1][0];
  assign grp_cnt_o = grp_cnt_q;
endmodule

// File: tb/tb_neumaier_pair_sched.sv
// tb_neumaier_pair_sched: table-driven vectors with a pair/tag scoreboard for neumaier_pair_sched
module tb_neumaier_pair_sched;
  localparam int W = 8;
  localparam int L = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0, last = 1'b0, flush = 1'b0;
  logic [W-1:0] sum = '0, comp = '0;
  logic ready_o, pair_valid_o, pair_last_o, merged_valid_o, merged_last_o;
  logic [W-1:0] sum_a_o, comp_a_o, sum_b_o, comp_b_o;
  logic [1:0] grp_cnt_o;

  always #5 clk = ~clk;

  neumaier_pair_sched #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .MERGE_LATENCY(L), .GRP_CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_o),
    .sum_i(sum), .comp_i(comp), .last_i(last), .flush_i(flush),
    .sum_a_o(sum_a_o), .comp_a_o(comp_a_o), .sum_b_o(sum_b_o), .comp_b_o(comp_b_o),
    .pair_valid_o(pair_valid_o), .pair_last_o(pair_last_o),
    .merged_valid_o(merged_valid_o), .merged_last_o(merged_last_o), .grp_cnt_o(grp_cnt_o)
  );

  typedef struct {
    logic v, l, f, fire, pl;
    logic [W-1:0] s, c, as, ac, bs, bc;
  } vec_t;
  typedef struct {
    int due;
    logic [W-1:0] as, ac, bs, bc;
    logic pl;
  } pair_t;
  typedef struct {
    int due;
    logic ml;
  } tag_t;

  pair_t pq[$];
  tag_t mq[$];
  vec_t tv[$];
  int edge_n = 0;
  int rel_edge = 1 << 30;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_grp = 2'd0;
  logic [W-1:0] exp_as = '0, exp_ac = '0, exp_bs = '0, exp_bc = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at edge %0d", n, act, exp, edge_n);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] s, input logic [W-1:0] c,
                              input logic l, input logic f, input logic fire,
                              input logic [W-1:0] as, input logic [W-1:0] ac,
                              input logic [W-1:0] bs, input logic [W-1:0] bc, input logic pl);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.l = l; t.f = f; t.fire = fire;
    t.as = as; t.ac = ac; t.bs = bs; t.bc = bc; t.pl = pl;
    return t;
  endfunction

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    pair_t p;
    tag_t m;
    logic exp_pv, exp_mv;
    chk("ready", 32'(ready_o), 32'(rst_n && edge_n >= rel_edge));
    exp_pv = pq.size() > 0 && pq[0].due == edge_n;
    chk("pair_valid", 32'(pair_valid_o), 32'(exp_pv));
    if (exp_pv) begin
      p = pq.pop_front();
      exp_as = p.as; exp_ac = p.ac; exp_bs = p.bs; exp_bc = p.bc;
      chk("pair_last", 32'(pair_last_o), 32'(p.pl));
      mq.push_back('{edge_n + L, p.pl});
    end
    chk("sum_a", 32'(sum_a_o), 32'(exp_as));
    chk("comp_a", 32'(comp_a_o), 32'(exp_ac));
    chk("sum_b", 32'(sum_b_o), 32'(exp_bs));
    chk("comp_b", 32'(comp_b_o), 32'(exp_bc));
    exp_mv = mq.size() > 0 && mq[0].due == edge_n;
    chk("merged_valid", 32'(merged_valid_o), 32'(exp_mv));
    chk("grp_cnt", 32'(grp_cnt_o), 32'(exp_grp));
    if (exp_mv) begin
      m = mq.pop_front();
      chk("merged_last", 32'(merged_last_o), 32'(m.ml));
      if (m.ml) exp_grp++;
    end
  end

  task automatic drive(input vec_t t);
    @(posedge clk);
    #1;
    valid = t.v; sum = t.s; comp = t.c; last = t.l; flush = t.f;
    if (t.fire) pq.push_back('{edge_n + 1, t.as, t.ac, t.bs, t.bc, t.pl});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(mk(0, 8'hFF, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_edge = edge_n + 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    #1;
    pq.delete();
    mq.delete();
    exp_grp = 2'd0;
    exp_as = '0; exp_ac = '0; exp_bs = '0; exp_bc = '0;
    rel_edge = 1 << 30;
    chk("rst_ready", 32'(ready_o), 32'(0));
    chk("rst_pair_valid", 32'(pair_valid_o), 32'(0));
    chk("rst_sum_a", 32'(sum_a_o), 32'(0));
    chk("rst_sum_b", 32'(sum_b_o), 32'(0));
    chk("rst_comp_a", 32'(comp_a_o), 32'(0));
    chk("rst_merged_valid", 32'(merged_valid_o), 32'(0));
    chk("rst_grp", 32'(grp_cnt_o), 32'(0));
    release_rst();
  endtask

  initial begin
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    // four-element group, two pairs
    tv.push_back(mk(1, 8'h3C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h40, 8'h00, 0, 0, 1, 8'h3C, 8'h00, 8'h40, 8'h00, 0));
    tv.push_back(mk(1, 8'h44, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h48, 8'h00, 1, 0, 1, 8'h44, 8'h00, 8'h48, 8'h00, 1));
    tv.push_back(mk(0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    // single-element group from EMPTY
    tv.push_back(mk(1, 8'h3C, 8'h05, 1, 0, 1, 8'h3C, 8'h05, 8'h00, 8'h00, 1));
    // hold, idle, flush, then a flush in EMPTY does nothing
    tv.push_back(mk(1, 8'h40, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 0, 1, 1, 8'h40, 8'h11, 8'h00, 8'h00, 1));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 0, 1, 0, 0, 0, 0, 0, 0));
    // accept with flush in HOLD: incoming wins, FSM back to EMPTY
    tv.push_back(mk(1, 8'h21, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h33, 8'h07, 0, 1, 1, 8'h21, 8'h02, 8'h33, 8'h07, 0));
    tv.push_back(mk(0, 8'hAA, 8'hAA, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 8'h55, 8'h01, 1, 0, 1, 8'h55, 8'h01, 8'h00, 8'h00, 1));
    release_rst();
    for (int i = 0; i < tv.size(); i++) drive(tv[i]);
    idle(8);
    // reset while holding with three tags in flight
    drive(mk(1, 8'h11, 8'h00, 1, 0, 1, 8'h11, 8'h00, 8'h00, 8'h00, 1));
    drive(mk(1, 8'h12, 8'h00, 1, 0, 1, 8'h12, 8'h00, 8'h00, 8'h00, 1));
    drive(mk(1, 8'h13, 8'h00, 1, 0, 1, 8'h13, 8'h00, 8'h00, 8'h00, 1));
    drive(mk(1, 8'h14, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();
    idle(10);
    // counter wrap with a 2-bit group counter; first single proves the held element was dropped
    for (int i = 0; i < 5; i++) begin
      drive(mk(1, 8'(8'h60 + i), 8'h03, 1, 0, 1, 8'(8'h60 + i), 8'h03, 8'h00, 8'h00, 1));
      idle(8);
      chk("grp_seq", 32'(grp_cnt_o), 32'(seq[i]));
    end
    idle(8);
    chk("drain", 32'(pq.size() + mq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
